la_capture_core: RTL and testbench
==================================

// Module: la_capture_core
// PURPOSE
//  Parametrised logic-analyser capture engine; successor to the fixed 8-bit sample controller.
//  Sits between the sample-rate divider (clk_en) and the wave-display buffer write port.
//  Adds runtime pre-trigger depth, selectable trigger channel and mode, abort, and a
//  frame-start address so the display can read the frame in chronological order.
// PARAMETERS
//  CHN        8   number of input channels (sample width), 1..32
//  ADDR_W     12  buffer address width; DEPTH = 2**ADDR_W samples
//  SEL_W      3   trigger-channel select width; must satisfy 2**SEL_W >= CHN
// PORTS
//  sys_clk      in   1       single capture/system clock
//  sys_rst_n    in   1       reset, asynchronous assert, active-low
//  clk_en       in   1       sample strobe from freq divider; one sample per high cycle
//  data_in      in   CHN     channel inputs, already synchronous to sys_clk
//  arm          in   1       1-cycle pulse: start (or restart) a capture
//  abort        in   1       1-cycle pulse: cancel capture, return to IDLE
//  trig_chn     in   SEL_W   trigger channel index, latched at arm
//  trig_mode    in   3       0 rise,1 fall,2 high,3 low,4 any edge,5-7 immediate; latched at arm
//  pre_trig     in   ADDR_W  samples kept before trigger; latched at arm, clamped to DEPTH-1
//  wr_en        out  1       buffer write strobe
//  wr_addr      out  ADDR_W  buffer write address
//  wr_data      out  CHN     buffer write data
//  busy         out  1       high in PRE, WAIT, POST
//  done         out  1       high in DONE until next arm/abort
//  trig_addr    out  ADDR_W  address of trigger sample (valid when done)
//  frame_start  out  ADDR_W  (trig_addr - pre_trig_latched) mod DEPTH (valid when done)
// BEHAVIOUR
//  Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, trig_addr=0,
//   frame_start=0; prev-sample register=0, prev_valid=0.
//  States: IDLE -> PRE -> WAIT -> POST -> DONE. arm in any state: latch config, wr_addr:=0,
//   prev_valid:=0, cnt:=pre_trig_clamped; go PRE (or WAIT if clamped value is 0).
//  abort (has priority over arm in same cycle): go IDLE, busy=0, done=0, wr_en=0 next cycle.
//  Sampling: on a clk_en cycle in PRE/WAIT/POST, data_in is registered -> wr_data, wr_en=1
//   next cycle (latency 1), wr_addr = current pointer; pointer then increments mod DEPTH.
//   wr_en is 0 on every other cycle and in IDLE/DONE.
//  PRE: every sample written, no trigger evaluation; cnt decrements; cnt reaching 0 -> WAIT.
//  WAIT: every sample written (circular, wraps DEPTH-1 -> 0); trigger evaluated on that sample:
//   rise: prev_valid & !prev[c] & cur[c]; fall: prev_valid & prev[c] & !cur[c];
//   high: cur[c]; low: !cur[c]; any edge: prev_valid & (prev[c]^cur[c]); 5-7: true.
//   On hit: trig_addr := this sample's address, cnt := DEPTH-1-pre_trig_clamped;
//   cnt==0 -> DONE directly, else -> POST.
//  POST: each sample written, cnt decrements; after the write making cnt 0 -> DONE.
//   Total samples from trigger to end inclusive = DEPTH - pre_trig_clamped.
//  prev/prev_valid update only on clk_en sample cycles (edge seen across samples, not clocks).
//  trig_chn >= CHN: channel treated as constant 0 (rise/fall/any never hit; low always hits).
//  DONE: busy=0, done=1, frame_start registered; outputs hold until arm or abort.
//  clk_en ignored in IDLE/DONE; arm and clk_en in same cycle: that sample is not taken.
// TESTING
//  CHN=8,ADDR_W=4; reset mid-POST -> all outputs 0, state IDLE next cycle after release.
//  pre_trig=4, mode 0 ch2, clk_en=1, bit2 rises on 10th sample -> trig_addr=9, 12 writes
//   after trigger incl., done=1, frame_start=5, wr_addr wraps 15->0 once.
//  pre_trig=0, mode 5 -> trigger on first sample: trig_addr=0, 16 writes 0..15, frame_start=0.
//  pre_trig=15 (max), mode 2 with ch high -> DONE straight after trigger sample, no POST writes.
//  clk_en every 3rd cycle, mode 1 -> wr_en spaced 3 cycles; edge spanning idle cycles detected.
//  abort during WAIT -> wr_en=0, busy=0, done=0 next cycle; arm+abort same cycle -> IDLE.

Source files
------------

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular pre-trigger buffer and trigger detection.
// Drives a post-trigger fill and a frame-start address for chronological readout.
module la_capture_core #(
    parameter int unsigned CHN    = 8,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              clk_en,
    input  logic [CHN-1:0]    data_in,
    input  logic              arm,
    input  logic              abort,
    input  logic [SEL_W-1:0]  trig_chn,
    input  logic [2:0]        trig_mode,
    input  logic [ADDR_W-1:0] pre_trig,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CHN-1:0]    wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] frame_start
);

    localparam int unsigned SEL_N = 2**SEL_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [SEL_W-1:0]  chn_q, chn_d;
    logic [2:0]        mode_q, mode_d;
    logic [CHN-1:0]    prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CHN-1:0]    wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] frame_start_q, frame_start_d;

    logic [SEL_N-1:0]  cur_ext, prev_ext;
    logic              cur_bit, prev_bit, hit, sample;

    // Zero-extending to 2**SEL_W bits makes any channel index >= CHN read as constant 0.
    always_comb begin
        cur_ext  = SEL_N'(data_in);
        prev_ext = SEL_N'(prev_q);
        cur_bit  = cur_ext[chn_q];
        prev_bit = prev_ext[chn_q];
        hit      = 1'b0;
        case (mode_q)
            3'd0:    hit = prev_valid_q & ~prev_bit & cur_bit;
            3'd1:    hit = prev_valid_q & prev_bit & ~cur_bit;
            3'd2:    hit = cur_bit;
            3'd3:    hit = ~cur_bit;
            3'd4:    hit = prev_valid_q & (prev_bit ^ cur_bit);
            default: hit = 1'b1;
        endcase
    end

    assign sample = clk_en & ((state_q == S_PRE) | (state_q == S_WAIT) | (state_q == S_POST));

    // Next-state and registered-output logic; abort beats arm, arm beats a sample.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        pre_d         = pre_q;
        chn_d         = chn_q;
        mode_d        = mode_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        trig_addr_d   = trig_addr_q;
        frame_start_d = frame_start_q;

        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (arm) begin
            // pre_trig is ADDR_W bits wide, so it can never exceed DEPTH-1.
            pre_d        = pre_trig;
            chn_d        = trig_chn;
            mode_d       = trig_mode;
            ptr_d        = '0;
            prev_valid_d = 1'b0;
            cnt_d        = pre_trig;
            state_d      = (pre_trig == '0) ? S_WAIT : S_PRE;
            busy_d       = 1'b1;
            done_d       = 1'b0;
        end else if (sample) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = ptr_q;
            wr_data_d    = data_in;
            ptr_d        = ptr_q + 1'b1;
            prev_d       = data_in;
            prev_valid_d = 1'b1;
            case (state_q)
                S_PRE: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (hit) begin
                        trig_addr_d = ptr_q;
                        // DEPTH-1-pre in ADDR_W bits is simply the complement of pre.
                        cnt_d = ~pre_q;
                        if (pre_q == {ADDR_W{1'b1}}) begin
                            state_d       = S_DONE;
                            busy_d        = 1'b0;
                            done_d        = 1'b1;
                            frame_start_d = ptr_q - pre_q;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d       = S_DONE;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        frame_start_d = trig_addr_q - pre_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            pre_q         <= '0;
            chn_q         <= '0;
            mode_q        <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            trig_addr_q   <= '0;
            frame_start_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            pre_q         <= pre_d;
            chn_q         <= chn_d;
            mode_q        <= mode_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            trig_addr_q   <= trig_addr_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign trig_addr   = trig_addr_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: randomized captures checked against a sample-list model
// that derives writes, trigger index and frame start from the recorded samples.
module tb_la_capture_core;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] trig_chn = 3'd0;
    logic [2:0] trig_mode = 3'd0;
    logic [3:0] pre_trig = 4'd0;
    logic       wr_en, busy, done;
    logic [3:0] wr_addr, trig_addr, frame_start;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] samp_q[$];
    int         wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];

    la_capture_core #(.CHN(8), .ADDR_W(4), .SEL_W(3)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .clk_en(clk_en), .data_in(data_in),
        .arm(arm), .abort(abort), .trig_chn(trig_chn), .trig_mode(trig_mode),
        .pre_trig(pre_trig), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .trig_addr(trig_addr), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every buffer write away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic chbit(input logic [7:0] v, input int c);
        logic [31:0] cc;
        cc = c;
        if (c >= 0 && c < 8) return v[cc[2:0]];
        return 1'b0;
    endfunction

    // Trigger rule applied to recorded sample i (edges are between consecutive samples).
    function automatic logic model_hit(input int i, input int mode, input int c);
        logic cur, prv, pv;
        cur = chbit(samp_q[i], c);
        pv  = (i > 0);
        prv = pv ? chbit(samp_q[i-1], c) : 1'b0;
        case (mode)
            0:       return pv && !prv && cur;
            1:       return pv && prv && !cur;
            2:       return cur;
            3:       return !cur;
            4:       return pv && (prv != cur);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] gen(input int kind, input int idx);
        logic [7:0] r;
        r = 8'($urandom);
        case (kind)
            1:       return (idx < 9) ? (r & 8'hFB) : (r | 8'h04);
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return r;
        endcase
    endfunction

    task automatic run_capture(input int pre, input int mode, input int chn, input int period,
                               input int kind, input bit arm_en, input string nm,
                               output int t_o, output int nw_o, output int wraps_o);
        int t, exp_n, wraps;
        bit fin;
        samp_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
        trig_chn  = 3'(chn);
        trig_mode = 3'(mode);
        pre_trig  = 4'(pre);
        arm       = 1'b1;
        clk_en    = arm_en;
        data_in   = 8'($urandom);
        tick;
        arm = 1'b0;
        fin = 1'b0;
        for (int n = 0; n < 600 && !fin; n++) begin
            clk_en  = ((n % period) == 0);
            data_in = clk_en ? gen(kind, samp_q.size()) : 8'($urandom);
            if (clk_en) samp_q.push_back(data_in);
            tick;
            if (done === 1'b1) fin = 1'b1;
        end
        clk_en = 1'b0;
        @(negedge clk);
        #1;

        t = -1;
        for (int i = pre; i < samp_q.size() && t < 0; i++)
            if (model_hit(i, mode, chn)) t = i;
        exp_n = (t < 0) ? -1 : t + DEPTH - pre;

        n_checks++;
        if (done !== 1'b1) $display("FAIL %s done: got %b want 1 (timeout)", nm, done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", nm, busy);
        else n_pass++;
        n_checks++;
        if (wa_q.size() !== exp_n) $display("FAIL %s write_count: got %0d want %0d", nm, wa_q.size(), exp_n);
        else n_pass++;
        for (int i = 0; i < wa_q.size() && i < samp_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== (i % DEPTH) || wd_q[i] !== samp_q[i])
                $display("FAIL %s write[%0d]: got a=%0d d=%h want a=%0d d=%h",
                         nm, i, wa_q[i], wd_q[i], i % DEPTH, samp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (trig_addr !== 4'(t)) $display("FAIL %s trig_addr: got %0d want %0d", nm, trig_addr, 4'(t));
        else n_pass++;
        n_checks++;
        if (frame_start !== 4'(t - pre)) $display("FAIL %s frame_start: got %0d want %0d", nm, frame_start, 4'(t - pre));
        else n_pass++;
        for (int i = 1; i < wc_q.size(); i++) begin
            n_checks++;
            if (wc_q[i] - wc_q[i-1] !== period)
                $display("FAIL %s spacing[%0d]: got %0d want %0d", nm, i, wc_q[i] - wc_q[i-1], period);
            else n_pass++;
        end
        wraps = 0;
        for (int i = 1; i < wa_q.size(); i++) if (wa_q[i] < wa_q[i-1]) wraps++;
        t_o = t; nw_o = wa_q.size(); wraps_o = wraps;
    endtask

    task automatic check_idle_outputs(input string nm);
        n_checks++;
        if ({wr_en, busy, done} !== 3'b000 || wr_addr !== 4'd0 || wr_data !== 8'd0 ||
            trig_addr !== 4'd0 || frame_start !== 4'd0)
            $display("FAIL %s outputs: got en=%b busy=%b done=%b a=%0d d=%h ta=%0d fs=%0d want all 0",
                     nm, wr_en, busy, done, wr_addr, wr_data, trig_addr, frame_start);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b1;
        tick;
        tick;
        check_idle_outputs("idle_after_reset");
        clk_en = 1'b0;
    endtask

    task automatic test_rise_wrap;
        int t, nw, wr;
        run_capture(4, 0, 2, 1, 1, 1'b0, "rise", t, nw, wr);
        n_checks++;
        if (trig_addr !== 4'd9 || frame_start !== 4'd5)
            $display("FAIL rise_fixed: got ta=%0d fs=%0d want ta=9 fs=5", trig_addr, frame_start);
        else n_pass++;
        n_checks++;
        if (nw - 9 !== 12 || wr !== 1)
            $display("FAIL rise_post: got post_writes=%0d wraps=%0d want 12 and 1", nw - 9, wr);
        else n_pass++;
    endtask

    task automatic test_immediate;
        int t, nw, wr;
        run_capture(0, 5, int'($urandom_range(0, 7)), 1, 0, 1'b0, "immediate", t, nw, wr);
        n_checks++;
        if (trig_addr !== 4'd0 || frame_start !== 4'd0 || nw !== 16)
            $display("FAIL immediate_fixed: got ta=%0d fs=%0d writes=%0d want 0 0 16", trig_addr, frame_start, nw);
        else n_pass++;
    endtask

    task automatic test_max_pre;
        int t, nw, wr;
        run_capture(15, 2, 3, 1, 2, 1'b0, "max_pre", t, nw, wr);
        n_checks++;
        if (trig_addr !== 4'd15 || frame_start !== 4'd0 || nw !== 16)
            $display("FAIL max_pre_fixed: got ta=%0d fs=%0d writes=%0d want 15 0 16", trig_addr, frame_start, nw);
        else n_pass++;
    endtask

    task automatic test_slow_fall;
        int t, nw, wr;
        run_capture(3, 1, 5, 3, 0, 1'b1, "slow_fall", t, nw, wr);
    endtask

    task automatic test_random;
        int t, nw, wr;
        for (int k = 0; k < 8; k++) begin
            run_capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 0,
                        1'($urandom_range(0, 1)), $sformatf("rand%0d", k), t, nw, wr);
        end
    endtask

    task automatic test_abort;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done);
        else n_pass++;
        trig_chn = 3'd3; trig_mode = 3'd0; pre_trig = 4'd0;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        clk_en = 1'b1; data_in = 8'h00;
        repeat (4) tick;
        n_checks++;
        if (busy !== 1'b1 || wr_en !== 1'b1) $display("FAIL wait_active: got busy=%b en=%b want 1 1", busy, wr_en);
        else n_pass++;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_checks++;
        if ({wr_en, busy, done} !== 3'b000) $display("FAIL abort_wait: got en/busy/done=%b want 000", {wr_en, busy, done});
        else n_pass++;
        repeat (2) tick;
        n_checks++;
        if (wr_en !== 1'b0) $display("FAIL abort_idle_en: got %b want 0", wr_en);
        else n_pass++;
        arm = 1'b1; abort = 1'b1;
        tick;
        arm = 1'b0; abort = 1'b0;
        tick;
        n_checks++;
        if ({wr_en, busy, done} !== 3'b000) $display("FAIL arm_abort: got en/busy/done=%b want 000", {wr_en, busy, done});
        else n_pass++;
        clk_en = 1'b0;
    endtask

    task automatic test_reset_mid_post;
        trig_chn = 3'd0; trig_mode = 3'd5; pre_trig = 4'd2;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        clk_en = 1'b1;
        repeat (5) begin
            data_in = 8'($urandom);
            tick;
        end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL post_active: got busy=%b done=%b want 1 0", busy, done);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_post");
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        check_idle_outputs("idle_after_mid_reset");
        clk_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_wrap();
        test_immediate();
        test_max_pre();
        test_slow_fall();
        test_random();
        test_abort();
        test_reset_mid_post();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
